// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXIS packet generator and its receive-side peers:
// FSM encoding, beat geometry and the last-beat tkeep/byte-mask helpers.
package axis_pkt_gen_pkg;

    // Generator FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int BYTES_PER_BEAT = 8;
    localparam int BEAT_DATA_W    = BYTES_PER_BEAT * 8;

    // Byte enables for the final beat given len[2:0]; a zero remainder
    // means the last beat is completely full.
    function automatic logic [BYTES_PER_BEAT-1:0] keep_from_rem(input logic [2:0] rem);
        logic [3:0] sh;
        sh = 4'd8 - {1'b0, rem};
        keep_from_rem = (rem == 3'd0) ? 8'hFF : (8'hFF >> sh);
    endfunction

    // Zero every byte lane whose keep bit is clear, so unused bytes on the
    // wire are deterministic.
    function automatic logic [BEAT_DATA_W-1:0] mask_bytes(
        input logic [BEAT_DATA_W-1:0]    data,
        input logic [BYTES_PER_BEAT-1:0] keep
    );
        logic [BEAT_DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            res[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
        end
        mask_bytes = res;
    endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: takes a byte-length command and emits one
// 64-bit packet of that many bytes, payload = free-running beat counter.
// All stream outputs are registered so they hold naturally under backpressure.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    // length command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len_bytes,
    // AXIS master
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    // status
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  len_err,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    // Beat count ceil(len/8) needs LEN_WIDTH-2 bits (65535 -> 8192).
    localparam int BL_W = LEN_WIDTH - 2;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic [BL_W-1:0]       r_beats_left;
    logic [2:0]            r_rem;
    logic [DATA_WIDTH-1:0] r_data_cnt;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_busy;
    logic                  r_pkt_done;
    logic                  r_len_err;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic                  w_cmd_fire;
    logic                  w_beat_fire;
    logic [LEN_WIDTH:0]    w_len_p7;
    logic [BL_W-1:0]       w_beats;
    logic [2:0]            w_rem;
    logic                  w_first_last;
    logic [KEEP_WIDTH-1:0] w_first_keep;
    logic [BL_W-1:0]       w_bl_dec;
    logic [DATA_WIDTH-1:0] w_data_inc;
    logic                  w_next_last;
    logic [KEEP_WIDTH-1:0] w_next_keep;

    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    assign w_beat_fire = r_tvalid & m_axis_tready;

    // Command decode: beats = ceil(len/8), remainder selects last-beat keep.
    assign w_len_p7     = {1'b0, cmd_len_bytes} + {{(LEN_WIDTH-2){1'b0}}, 3'd7};
    assign w_beats      = w_len_p7[LEN_WIDTH:3];
    assign w_rem        = cmd_len_bytes[2:0];
    assign w_first_last = (w_beats == {{(BL_W-1){1'b0}}, 1'b1});
    assign w_first_keep = w_first_last ? keep_from_rem(w_rem) : {KEEP_WIDTH{1'b1}};

    // Contents of the beat that follows an accepted non-last beat.
    assign w_bl_dec    = r_beats_left - {{(BL_W-1){1'b0}}, 1'b1};
    assign w_data_inc  = r_data_cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign w_next_last = (w_bl_dec == {{(BL_W-1){1'b0}}, 1'b1});
    assign w_next_keep = w_next_last ? keep_from_rem(r_rem) : {KEEP_WIDTH{1'b1}};

    // Generator FSM: owns every registered output, including the beat
    // presented on the stream, which is loaded one beat ahead of its handshake.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_beats_left <= '0;
            r_rem        <= '0;
            r_data_cnt   <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_tkeep      <= '0;
            r_busy       <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_len_err    <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            r_len_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        if (cmd_len_bytes == '0) begin
                            // zero-length request: flag it, send nothing
                            r_len_err <= 1'b1;
                        end else begin
                            r_state      <= ST_SEND;
                            r_cmd_ready  <= 1'b0;
                            r_busy       <= 1'b1;
                            r_beats_left <= w_beats;
                            r_rem        <= w_rem;
                            r_tvalid     <= 1'b1;
                            r_tlast      <= w_first_last;
                            r_tkeep      <= w_first_keep;
                            r_tdata      <= mask_bytes(r_data_cnt, w_first_keep);
                        end
                    end
                end
                ST_SEND: begin
                    if (w_beat_fire) begin
                        r_data_cnt   <= w_data_inc;
                        r_beats_left <= w_bl_dec;
                        if (r_tlast) begin
                            r_state     <= ST_IDLE;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_tkeep     <= '0;
                            r_tdata     <= '0;
                            r_pkt_done  <= 1'b1;
                            r_pkt_cnt   <= r_pkt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            r_tlast <= w_next_last;
                            r_tkeep <= w_next_keep;
                            r_tdata <= mask_bytes(w_data_inc, w_next_keep);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tkeep  = r_tkeep;
    assign busy          = r_busy;
    assign pkt_done      = r_pkt_done;
    assign len_err       = r_len_err;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: a table of packet commands with
// hand-computed beat counts, last-beat keep and starting payload values,
// plus hand-written reset sequences.
module tb_axis_pkt_gen;

    logic        axis_aclk;
    logic        axis_aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len_bytes;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tkeep;
    logic        busy;
    logic        pkt_done;
    logic        len_err;
    logic [31:0] pkt_cnt;

    axis_pkt_gen dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len_bytes (cmd_len_bytes),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .len_err       (len_err),
        .pkt_cnt       (pkt_cnt)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        int          len;
        bit          stall;   // tready 1-on/2-off instead of always 1
        int          beats;   // 0 => zero-length command
        logic [7:0]  keep;    // tkeep expected on the last beat
        logic [63:0] first;   // tdata of the first beat
        int          cnt;     // pkt_cnt after the packet
    } vec_t;

    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] bmask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Present a command at a negedge once cmd_ready is seen; returns on the
    // negedge after the accepting edge, with the length bus scrambled.
    task automatic send_cmd(input int len);
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge axis_aclk);
            t++;
        end
        chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid     = 1'b1;
        cmd_len_bytes = 16'(len);
        @(posedge axis_aclk);
        #1;
        cmd_valid     = 1'b0;
        cmd_len_bytes = 16'h5A5A;
        @(negedge axis_aclk);
    endtask

    task automatic run_pkt(input vec_t v);
        int          nb, cyc, phase;
        int          e_valid, e_data, e_keep, e_last, e_stable, e_busy;
        bit          prev_stall, rdy, exp_last;
        logic [7:0]  exp_k;
        logic [63:0] exp_d;
        logic [72:0] hold;
        send_cmd(v.len);
        if (v.beats == 0) begin
            chk("len_err_pulse", 64'(len_err), 64'd1);
            chk("zero_len_no_tvalid", 64'(m_axis_tvalid), 64'd0);
            chk("zero_len_stay_idle", 64'(cmd_ready), 64'd1);
            @(negedge axis_aclk);
            chk("len_err_one_cycle", 64'(len_err), 64'd0);
            chk("zero_len_pkt_cnt", 64'(pkt_cnt), 64'(v.cnt));
            return;
        end
        chk("first_beat_latency", 64'(m_axis_tvalid), 64'd1);
        chk("pkt_done_low_in_pkt", 64'(pkt_done), 64'd0);
        nb = 0; cyc = 0; phase = 1; prev_stall = 0; hold = '0;
        e_valid = 0; e_data = 0; e_keep = 0; e_last = 0; e_stable = 0; e_busy = 0;
        while (nb < v.beats && cyc < 40000) begin
            if (!m_axis_tvalid) e_valid++;
            else begin
                exp_last = (nb == v.beats - 1);
                exp_k    = exp_last ? v.keep : 8'hFF;
                exp_d    = bmask(v.first + 64'(nb), exp_k);
                if (m_axis_tdata !== exp_d) begin
                    if (e_data == 0)
                        $display("beat %0d tdata %0h want %0h", nb, m_axis_tdata, exp_d);
                    e_data++;
                end
                if (m_axis_tkeep !== exp_k) e_keep++;
                if (m_axis_tlast !== exp_last) e_last++;
                if (prev_stall && {m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== hold) e_stable++;
            end
            if (!busy) e_busy++;
            rdy   = v.stall ? (phase == 0) : 1'b1;
            phase = (phase == 2) ? 0 : phase + 1;
            m_axis_tready = rdy;
            if (m_axis_tvalid && rdy) nb++;
            prev_stall = m_axis_tvalid && !rdy;
            hold = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            @(negedge axis_aclk);
            cyc++;
        end
        m_axis_tready = 1'b1;
        chk("beat_count", 64'(nb), 64'(v.beats));
        chk("tvalid_held_in_pkt", 64'(e_valid), 64'd0);
        chk("tdata_errors", 64'(e_data), 64'd0);
        chk("tkeep_errors", 64'(e_keep), 64'd0);
        chk("tlast_errors", 64'(e_last), 64'd0);
        if (v.stall) chk("stall_stability_errors", 64'(e_stable), 64'd0);
        chk("busy_in_pkt_errors", 64'(e_busy), 64'd0);
        chk("pkt_done_pulse", 64'(pkt_done), 64'd1);
        chk("pkt_cnt", 64'(pkt_cnt), 64'(v.cnt));
        chk("idle_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("busy_after_pkt", 64'(busy), 64'd0);
        chk("cmd_ready_after_pkt", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        vec_t big;
        vecs[0] = '{len: 164, stall: 0, beats: 21, keep: 8'h0F, first: 64'd1,  cnt: 1};
        vecs[1] = '{len: 8,   stall: 0, beats: 1,  keep: 8'hFF, first: 64'd22, cnt: 2};
        vecs[2] = '{len: 9,   stall: 0, beats: 2,  keep: 8'h01, first: 64'd23, cnt: 3};
        vecs[3] = '{len: 0,   stall: 0, beats: 0,  keep: 8'h00, first: 64'd0,  cnt: 3};
        vecs[4] = '{len: 40,  stall: 1, beats: 5,  keep: 8'hFF, first: 64'd25, cnt: 4};
        vecs[5] = '{len: 1,   stall: 0, beats: 1,  keep: 8'h01, first: 64'd30, cnt: 5};
        vecs[6] = '{len: 15,  stall: 1, beats: 2,  keep: 8'h7F, first: 64'd31, cnt: 6};
        big     = '{len: 65535, stall: 0, beats: 8192, keep: 8'h7F, first: 64'd1, cnt: 1};

        axis_aresetn  = 1'b0;
        cmd_valid     = 1'b0;
        cmd_len_bytes = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge axis_aclk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
        chk("rst_status", 64'({busy, pkt_done, len_err}), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

        // Reset while beat 3 of a 64-byte packet is on the wire (data 33..40).
        send_cmd(64);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10 && !(m_axis_tvalid && m_axis_tdata == 64'd35); i++)
            @(negedge axis_aclk);
        chk("reached_beat3", m_axis_tdata, 64'd35);
        axis_aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid_drops", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_no_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk("cmd_ready_after_mid_rst", 64'(cmd_ready), 64'd1);

        // Maximum length, data counter restarted at 1 by the reset.
        run_pkt(big);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
